// File: rtl/sta_pkg.sv
// sta_pkg: shared FSM type, default widths and parameter legality checks for the stats RAM reader
package sta_pkg;
   localparam int DEF_ADDR_WIDTH = 4;
   localparam int DEF_DATA_WIDTH = 64;
   typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;
   // RAM read latency is 1 without the RAM output register and 2 with it
   function automatic bit rd_latency_ok(input int lat);
      return (lat == 1) || (lat == 2);
   endfunction
   // FIFO must be a power of two and hold every word that can be in flight plus one
   function automatic bit fifo_depth_ok(input int depth, input int lat);
      return (depth >= lat + 2) && ((depth & (depth - 1)) == 0);
   endfunction
endpackage

// File: rtl/sta_rd_fifo.sv
// sta_rd_fifo: synchronous FIFO whose head word sits in a registered output stage
// Ports:
//   rd_clk_tb, tb_rst   clock, asynchronous active-high reset
//   push, din           write strobe and word
//   pop                 consume the word on dout (ignored while dout_valid is low)
//   dout, dout_valid    registered head word and its valid flag
//   count, empty, full  occupancy of the storage array (output stage excluded)
module sta_rd_fifo #(
   parameter int WIDTH = 68,
   parameter int DEPTH = 4
) (
   input  logic                     rd_clk_tb,
   input  logic                     tb_rst,
   input  logic                     push,
   input  logic [WIDTH-1:0]         din,
   input  logic                     pop,
   output logic [WIDTH-1:0]         dout,
   output logic                     dout_valid,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full
);
   localparam int PW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr, rd_ptr;
   logic             ld;
   // refill the output stage whenever it is free or being consumed this cycle
   assign ld    = (count != '0) && (!dout_valid || pop);
   assign empty = (count == '0);
   assign full  = (count == ($clog2(DEPTH)+1)'(DEPTH));
   always_ff @(posedge rd_clk_tb) begin
      if (push) mem[wr_ptr] <= din;
   end
   always_ff @(posedge rd_clk_tb or posedge tb_rst) begin
      if (tb_rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
      end else begin
         wr_ptr     <= push ? wr_ptr + 1'b1 : wr_ptr;
         rd_ptr     <= ld ? rd_ptr + 1'b1 : rd_ptr;
         dout       <= ld ? mem[rd_ptr] : dout;
         dout_valid <= ld ? 1'b1 : pop ? 1'b0 : dout_valid;
         count      <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, ld};
      end
   end
endmodule

// File: rtl/sta_ram_reader.sv
// sta_ram_reader: sweeps the stats RAM once per start and streams every word with index, last flag and XOR checksum
// Ports:
//   rd_clk_tb, tb_rst                       read-domain clock, asynchronous active-high reset
//   start, busy, done                       sweep request, sweep in progress, end-of-sweep pulse
//   checksum                                XOR of all words of the last completed sweep
//   ram_rd_addr, ram_rd_data                RAM read port (address registered here)
//   m_data, m_index, m_valid, m_ready, m_last  output stream
module sta_ram_reader
   import sta_pkg::*;
#(
   parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
   parameter int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter int RD_LATENCY = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  rd_clk_tb,
   input  logic                  tb_rst,
   input  logic                  start,
   output logic                  busy,
   output logic                  done,
   output logic [DATA_WIDTH-1:0] checksum,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic [ADDR_WIDTH-1:0] m_index,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  m_last
);
   localparam int FW = ADDR_WIDTH + DATA_WIDTH;
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;
   if (!rd_latency_ok(RD_LATENCY)) begin : g_bad_latency
      $error("sta_ram_reader: RD_LATENCY must be 1 or 2");
   end
   if (!fifo_depth_ok(FIFO_DEPTH, RD_LATENCY)) begin : g_bad_depth
      $error("sta_ram_reader: FIFO_DEPTH must be a power of two >= RD_LATENCY+2");
   end
   state_t                              state, state_nxt;
   logic [ADDR_WIDTH:0]                 cnt;
   logic [ADDR_WIDTH-1:0]               beat;
   logic [RD_LATENCY:0]                 sr_v;
   logic [RD_LATENCY:0][ADDR_WIDTH-1:0] sr_tag;
   logic [DATA_WIDTH-1:0]               acc;
   logic [CW-1:0]                       fifo_count;
   logic [FW-1:0]                       fifo_dout;
   logic                                fifo_full, fifo_empty_unused;
   logic                                go, issue, hs, credit, done_nxt;
   // a start coinciding with done belongs to the finishing sweep and is dropped
   assign go       = (state == IDLE) && start && !done;
   assign hs       = m_valid && m_ready;
   // every in-flight read already owns a FIFO slot, so captures can never overflow
   assign credit   = ($countones(sr_v) + int'(fifo_count)) < FIFO_DEPTH;
   assign busy     = (state != IDLE);
   assign {m_index, m_data} = fifo_dout;
   assign m_last   = m_valid && (m_index == LAST_ADDR);
   always_ff @(posedge rd_clk_tb or posedge tb_rst) begin
      if (tb_rst) state <= IDLE;
      else        state <= state_nxt;
   end
   always_comb begin
      state_nxt = state;
      issue     = 1'b0;
      done_nxt  = 1'b0;
      case (state)
         IDLE:  state_nxt = go ? SWEEP : IDLE;
         SWEEP: begin
            issue = credit && !fifo_full && !cnt[ADDR_WIDTH];
            if (issue && cnt[ADDR_WIDTH-1:0] == LAST_ADDR) state_nxt = DRAIN;
         end
         DRAIN: begin
            done_nxt = hs && (beat == LAST_ADDR);
            if (done_nxt) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end
   // the tag pipeline mirrors the RAM latency: a tag leaving the last stage
   // lines up with that address's word on ram_rd_data
   always_ff @(posedge rd_clk_tb or posedge tb_rst) begin
      if (tb_rst) begin
         cnt         <= '0;
         beat        <= '0;
         ram_rd_addr <= '0;
         sr_v        <= '0;
         sr_tag      <= '0;
         acc         <= '0;
         checksum    <= '0;
         done        <= 1'b0;
      end else begin
         done        <= done_nxt;
         sr_v        <= {sr_v[RD_LATENCY-1:0], issue};
         sr_tag      <= {sr_tag[RD_LATENCY-1:0], cnt[ADDR_WIDTH-1:0]};
         cnt         <= go ? '0 : issue ? cnt + 1'b1 : cnt;
         ram_rd_addr <= issue ? cnt[ADDR_WIDTH-1:0] : ram_rd_addr;
         beat        <= go ? '0 : hs ? beat + 1'b1 : beat;
         acc         <= go ? '0 : hs ? acc ^ m_data : acc;
         checksum    <= done_nxt ? acc ^ m_data : checksum;
      end
   end
   sta_rd_fifo #(
      .WIDTH (FW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .rd_clk_tb  (rd_clk_tb),
      .tb_rst     (tb_rst),
      .push       (sr_v[RD_LATENCY]),
      .din        ({sr_tag[RD_LATENCY], ram_rd_data}),
      .pop        (hs),
      .dout       (fifo_dout),
      .dout_valid (m_valid),
      .count      (fifo_count),
      .empty      (fifo_empty_unused),
      .full       (fifo_full)
   );
endmodule
